// File: rtl/money_display_scanner_if.sv
// Bus between the vending machine core and the money display stage.
//   value    : binary money count driven by the core
//   digit    : one-hot digit enables, bit0 = least significant digit
//   seg      : segments {A,B,C,D,E,F,G}, active-high
//   seg_dp   : decimal point (held low)
//   busy     : binary-to-BCD conversion in progress
//   overflow : committed value does not fit in the digit count
// master = value source (core / bench), slave = display stage.
interface money_display_scanner_if #(
  parameter int BIN_W      = 8,
  parameter int NUM_DIGITS = 6
);
  logic [BIN_W-1:0]      value;
  logic [NUM_DIGITS-1:0] digit;
  logic [6:0]            seg;
  logic                  seg_dp;
  logic                  busy;
  logic                  overflow;

  modport master (output value, input digit, seg, seg_dp, busy, overflow);
  modport slave  (input value, output digit, seg, seg_dp, busy, overflow);
endinterface

// File: rtl/money_display_scanner.sv
// Money display stage: converts the binary money count to BCD with a
// sequential double-dabble engine and scans a multiplexed 7-segment display
// with leading-zero blanking and an all-dash overflow indication.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : slave side of money_display_scanner_if (value in; digit, seg,
//         seg_dp, busy, overflow out)
module money_display_scanner #(
  parameter int BIN_W      = 8,
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 10,
  parameter int BLANK_LZ   = 1
) (
  input logic                   clk,
  input logic                   rst,
  money_display_scanner_if.slave bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Add 3 to every nibble that is 5 or more (double-dabble correction).
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (b[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = b[4*n +: 4] + 4'd3;
      end else begin
        r[4*n +: 4] = b[4*n +: 4];
      end
    end
    return r;
  endfunction

  // BCD nibble to {A..G}; codes above 9 cannot occur and show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110010;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  state_t            state_r, state_next_s;
  logic [BIN_W-1:0]  last_val_r;
  logic [BIN_W-1:0]  bin_r;
  logic [BCD_W-1:0]  bcd_r;
  logic [BCD_W-1:0]  bcd_adj_s;
  logic              ovf_acc_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [BCD_W-1:0]  disp_bcd_r;
  logic              overflow_r;
  logic              busy_r;

  logic [PW-1:0]         presc_r;
  logic [IW-1:0]         idx_r, idx_next_s;
  logic                  wrap_s;
  logic [NUM_DIGITS-1:0] digit_r, digit_next_s;
  logic [6:0]            seg_r, seg_next_s;
  logic [BCD_W-1:0]      upper_s;

  assign bcd_adj_s = bcd_adjust(bcd_r);

  // Converter next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.value != last_val_r) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == CNT_W'(BIN_W - 1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Converter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Converter datapath: latch, shift/adjust, commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_val_r <= '0;
      bin_r      <= '0;
      bcd_r      <= '0;
      ovf_acc_r  <= 1'b0;
      bit_cnt_r  <= '0;
      disp_bcd_r <= '0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.value != last_val_r) begin
            last_val_r <= bus.value;
            bin_r      <= bus.value;
            bcd_r      <= '0;
            ovf_acc_r  <= 1'b0;
            bit_cnt_r  <= '0;
          end
        end
        SHIFT: begin
          // The bit leaving the top nibble would be a carry into a digit
          // that does not exist, so it marks overflow.
          bcd_r     <= {bcd_adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
          bin_r     <= {bin_r[BIN_W-2:0], 1'b0};
          ovf_acc_r <= ovf_acc_r | bcd_adj_s[BCD_W-1];
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
        DONE: begin
          disp_bcd_r <= bcd_r;
          overflow_r <= ovf_acc_r;
        end
        default: begin
          bcd_r <= bcd_r;
        end
      endcase
    end
  end

  // Scanner: next digit index and its segment pattern.
  always_comb begin
    wrap_s       = (presc_r == PW'(SCAN_DIV - 1));
    idx_next_s   = (idx_r == IW'(NUM_DIGITS - 1)) ? '0 : idx_r + IW'(1);
    digit_next_s = NUM_DIGITS'(1) << idx_next_s;
    // Nibble of the next digit lands in bits [3:0]; all-zero means this digit
    // and every more significant one are zero.
    upper_s      = disp_bcd_r >> {idx_next_s, 2'b00};
    if (overflow_r) begin
      seg_next_s = 7'b0000001;
    end else if ((BLANK_LZ != 0) && (idx_next_s != '0) && (upper_s == '0)) begin
      seg_next_s = 7'b0000000;
    end else begin
      seg_next_s = seg_decode(upper_s[3:0]);
    end
  end

  // Scanner registers: digit enable and segments change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= '0;
      digit_r <= NUM_DIGITS'(1);
      seg_r   <= 7'b1111110;
    end else if (wrap_s) begin
      presc_r <= '0;
      idx_r   <= idx_next_s;
      digit_r <= digit_next_s;
      seg_r   <= seg_next_s;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign bus.digit    = digit_r;
  assign bus.seg      = seg_r;
  assign bus.seg_dp   = 1'b0;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;

endmodule
